axi_aw_rr_arbiter: RTL and testbench

- Arbitrates AW requests from N_TARG_PORT target-side ports onto one initiator-side AW channel.
- Uses a round-robin scheme with grant lock: once awvalid_o is raised for a requester, that grant is held until the AW handshake completes, so valid stays stable as AXI requires.
- On each accepted AW, pushes the winner's port index into the W-routing FIFO, which steers the W beats that follow.
- Instantiated once per initiator port, downstream of the per-target address decoders.

---
 rtl/axi_aw_rr_arbiter_if.sv | 24 ++
 rtl/axi_aw_rr_arbiter.sv | 107 ++++++++++
 tb/tb_axi_aw_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_aw_rr_arbiter_if.sv
// rtl/axi_aw_rr_arbiter_if.sv - AW request/grant bundle between target ports, initiator port and W-routing FIFO
interface axi_aw_rr_arbiter_if #(
  parameter int N_TARG_PORT = 8,
  parameter int LOG_N_TARG  = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1
);
  logic [N_TARG_PORT-1:0] awvalid_i;
  logic [N_TARG_PORT-1:0] awready_o;
  logic                   awvalid_o;
  logic                   awready_i;
  logic [LOG_N_TARG-1:0]  sel_o;
  logic                   wfifo_gnt_i;
  logic                   wfifo_push_o;
  logic [LOG_N_TARG-1:0]  wfifo_id_o;

  modport master (
    input  awvalid_i, awready_i, wfifo_gnt_i,
    output awready_o, awvalid_o, sel_o, wfifo_push_o, wfifo_id_o
  );

  modport slave (
    output awvalid_i, awready_i, wfifo_gnt_i,
    input  awready_o, awvalid_o, sel_o, wfifo_push_o, wfifo_id_o
  );
endinterface

// File: rtl/axi_aw_rr_arbiter.sv
// rtl/axi_aw_rr_arbiter.sv - round-robin AW arbiter with grant lock and W-routing FIFO push
module axi_aw_rr_arbiter #(
  parameter int N_TARG_PORT = 8,
  parameter int LOG_N_TARG  = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1
) (
  input logic                 clk,
  input logic                 rst_n,
  axi_aw_rr_arbiter_if.master aw
);

  localparam int PAD_W = 2 ** LOG_N_TARG;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [LOG_N_TARG-1:0] rr_ptr;
  logic [LOG_N_TARG-1:0] lock_id;

  logic [PAD_W-1:0]      req_pad;
  logic [PAD_W-1:0]      gnt_pad;
  logic [LOG_N_TARG:0]   cand;
  logic [LOG_N_TARG-1:0] winner;
  logic                  found;
  logic                  any_req;
  logic [LOG_N_TARG-1:0] sel;
  logic                  valid;
  logic                  fire;
  logic [LOG_N_TARG-1:0] next_ptr;

  // Pad requests to a power-of-two width so any index value is a legal select.
  always_comb begin
    req_pad                  = '0;
    req_pad[N_TARG_PORT-1:0] = aw.awvalid_i;
  end

  assign any_req = |aw.awvalid_i;

  // Scan from rr_ptr upward, wrapping at N_TARG_PORT rather than at the index width.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int off = 0; off < N_TARG_PORT; off++) begin
      cand = {1'b0, rr_ptr} + (LOG_N_TARG+1)'(off);
      if (cand >= (LOG_N_TARG+1)'(N_TARG_PORT))
        cand = cand - (LOG_N_TARG+1)'(N_TARG_PORT);
      if (!found && req_pad[cand[LOG_N_TARG-1:0]]) begin
        winner = cand[LOG_N_TARG-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    sel   = rr_ptr;
    valid = 1'b0;
    fire  = 1'b0;
    if (state == IDLE) begin
      if (any_req && aw.wfifo_gnt_i) begin
        sel   = winner;
        valid = 1'b1;
        fire  = aw.awready_i;
      end
    end else begin
      // FIFO space was reserved when the lock was taken, so wfifo_gnt_i is not looked at here.
      sel   = lock_id;
      valid = req_pad[lock_id];
      fire  = req_pad[lock_id] && aw.awready_i;
    end
    if (!rst_n) begin
      sel   = '0;
      valid = 1'b0;
      fire  = 1'b0;
    end
  end

  always_comb begin
    gnt_pad = '0;
    if (fire)
      gnt_pad[sel] = 1'b1;
  end

  assign next_ptr = (sel == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      if (fire) begin
        rr_ptr <= next_ptr;
        state  <= IDLE;
      end else if (state == IDLE && valid) begin
        lock_id <= sel;
        state   <= LOCKED;
      end
    end
  end

  assign aw.awvalid_o    = valid;
  assign aw.awready_o    = gnt_pad[N_TARG_PORT-1:0];
  assign aw.sel_o        = sel;
  assign aw.wfifo_push_o = fire;
  assign aw.wfifo_id_o   = sel;

endmodule

// File: tb/tb_axi_aw_rr_arbiter.sv
// tb/tb_axi_aw_rr_arbiter.sv - self-checking bench for axi_aw_rr_arbiter (8-port and 6-port instances)
module tb_axi_aw_rr_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  axi_aw_rr_arbiter_if #(.N_TARG_PORT(8)) a8 ();
  axi_aw_rr_arbiter_if #(.N_TARG_PORT(6)) a6 ();

  axi_aw_rr_arbiter #(.N_TARG_PORT(8)) dut8 (.clk(clk), .rst_n(rst_n), .aw(a8.master));
  axi_aw_rr_arbiter #(.N_TARG_PORT(6)) dut6 (.clk(clk), .rst_n(rst_n), .aw(a6.master));

  always #5 clk = ~clk;

  // Packed view: {awvalid, sel, awready, push, id}
  function automatic logic [15:0] obs8();
    return {a8.awvalid_o, a8.sel_o, a8.awready_o, a8.wfifo_push_o, a8.wfifo_id_o};
  endfunction

  function automatic logic [13:0] obs6();
    return {a6.awvalid_o, a6.sel_o, a6.awready_o, a6.wfifo_push_o, a6.wfifo_id_o};
  endfunction

  function automatic logic [15:0] exp8(input bit v, input int s, input logic [7:0] r, input bit p);
    return {v, 3'(s), r, p, 3'(s)};
  endfunction

  function automatic logic [13:0] exp6(input bit v, input int s, input logic [5:0] r, input bit p);
    return {v, 3'(s), r, p, 3'(s)};
  endfunction

  task automatic drive8(input logic [7:0] req, input bit gnt, input bit rdy);
    a8.awvalid_i = req; a8.wfifo_gnt_i = gnt; a8.awready_i = rdy;
  endtask

  task automatic drive6(input logic [5:0] req, input bit gnt, input bit rdy);
    a6.awvalid_i = req; a6.wfifo_gnt_i = gnt; a6.awready_i = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive8(8'h00, 1'b0, 1'b0);
    drive6(6'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Reference: scan ports in order from the pointer modulo n; a locked grant owns the channel.
  task automatic model_eval(input int n, input int ptr, input bit locked, input int lid,
                            input logic [7:0] req, input bit gnt, input bit rdy,
                            output bit ev, output int es, output bit ep, output bit sel_known);
    logic [7:0] live;
    live = req & 8'((1 << n) - 1);
    ev = 1'b0; es = ptr; sel_known = 1'b1;
    if (locked) begin
      es = lid;
      ev = req[lid];
    end else if (gnt) begin
      for (int k = 0; k < n; k++) begin
        if (req[(ptr + k) % n]) begin
          es = (ptr + k) % n;
          ev = 1'b1;
          break;
        end
      end
    end else if (live != 8'h00) begin
      sel_known = 1'b0;
    end
    ep = ev && rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive8(8'hff, 1'b1, 1'b1);
    drive6(6'h3f, 1'b1, 1'b1);
    #2;
    checks++;
    if (obs8() !== 16'h0) begin errors++; $display("FAIL reset_outputs8: got %h expected %h", obs8(), 16'h0); end
    checks++;
    if (obs6() !== 14'h0) begin errors++; $display("FAIL reset_outputs6: got %h expected %h", obs6(), 14'h0); end
    do_reset();
  endtask

  task automatic test_single_port();
    do_reset();
    drive8(8'h08, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (obs8() !== exp8(1, 3, 8'h08, 1)) begin errors++; $display("FAIL single_port_grant: got %h expected %h", obs8(), exp8(1, 3, 8'h08, 1)); end
    @(posedge clk); #1;
    drive8(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs8() !== exp8(0, 4, 8'h00, 0)) begin errors++; $display("FAIL single_port_ptr_advance: got %h expected %h", obs8(), exp8(0, 4, 8'h00, 0)); end
  endtask

  task automatic test_all_ports();
    int cnt[8];
    foreach (cnt[i]) cnt[i] = 0;
    do_reset();
    drive8(8'hff, 1'b1, 1'b1);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (obs8() !== exp8(1, c % 8, 8'(1 << (c % 8)), 1)) begin
        errors++; $display("FAIL all_ports_order c=%0d: got %h expected %h", c, obs8(), exp8(1, c % 8, 8'(1 << (c % 8)), 1));
      end
      if (c < 8 && a8.wfifo_push_o === 1'b1) cnt[a8.sel_o]++;
      @(posedge clk); #1;
    end
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (cnt[p] !== 1) begin errors++; $display("FAIL all_ports_fairness port=%0d: got %0d grants expected 1", p, cnt[p]); end
    end
  endtask

  task automatic test_lock();
    int pushes = 0;
    do_reset();
    drive8(8'h08, 1'b1, 1'b1);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      // Port 2 joins after the lock; FIFO grant drops while locked and must not matter.
      if (c == 0) drive8(8'h20, 1'b1, 1'b0);
      else if (c < 3) drive8(8'h24, 1'b0, 1'b0);
      else drive8(8'h24, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (obs8() !== exp8(1, 5, (c == 3) ? 8'h20 : 8'h00, c == 3)) begin
        errors++; $display("FAIL lock_hold c=%0d: got %h expected %h", c, obs8(), exp8(1, 5, (c == 3) ? 8'h20 : 8'h00, c == 3));
      end
      if (a8.wfifo_push_o === 1'b1) pushes++;
      @(posedge clk); #1;
    end
    checks++;
    if (pushes !== 1) begin errors++; $display("FAIL lock_push_count: got %0d expected 1", pushes); end
    drive8(8'h04, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (obs8() !== exp8(1, 2, 8'h04, 1)) begin errors++; $display("FAIL lock_next_grant: got %h expected %h", obs8(), exp8(1, 2, 8'h04, 1)); end
  endtask

  task automatic test_fifo_stall();
    do_reset();
    drive8(8'h02, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({a8.awvalid_o, a8.awready_o, a8.wfifo_push_o} !== 10'h0) begin
        errors++; $display("FAIL fifo_stall c=%0d: got %h expected 000", c, {a8.awvalid_o, a8.awready_o, a8.wfifo_push_o});
      end
      @(posedge clk); #1;
    end
    drive8(8'h02, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (obs8() !== exp8(1, 1, 8'h02, 1)) begin errors++; $display("FAIL fifo_release: got %h expected %h", obs8(), exp8(1, 1, 8'h02, 1)); end
  endtask

  task automatic test_n6_wrap();
    int exp_sel[4] = '{4, 5, 0, 5};
    logic [5:0] reqs[4] = '{6'h10, 6'h21, 6'h21, 6'h21};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive6(reqs[c], 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (obs6() !== exp6(1, exp_sel[c], 6'(1 << exp_sel[c]), 1)) begin
        errors++; $display("FAIL n6_wrap c=%0d: got %h expected %h", c, obs6(), exp6(1, exp_sel[c], 6'(1 << exp_sel[c]), 1));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_locked();
    do_reset();
    drive8(8'h02, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (obs8() !== exp8(1, 1, 8'h00, 0)) begin errors++; $display("FAIL reset_locked_pre: got %h expected %h", obs8(), exp8(1, 1, 8'h00, 0)); end
    drive8(8'h02, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs8() !== 16'h0) begin errors++; $display("FAIL reset_locked_async: got %h expected %h", obs8(), 16'h0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive8(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs8() !== exp8(0, 0, 8'h00, 0)) begin errors++; $display("FAIL reset_locked_ptr: got %h expected %h", obs8(), exp8(0, 0, 8'h00, 0)); end
    @(posedge clk); #1;
    drive8(8'h04, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs8() !== exp8(1, 2, 8'h00, 0)) begin errors++; $display("FAIL reset_locked_idle: got %h expected %h", obs8(), exp8(1, 2, 8'h00, 0)); end
  endtask

  task automatic test_random();
    int  mp[2];
    bit  ml[2];
    int  mi[2];
    logic [7:0] r8, r6;
    bit  g8, g6, y8, y6, ev, ep, sk;
    int  es;
    logic [15:0] m8;
    logic [13:0] m6;
    do_reset();
    mp = '{0, 0}; ml = '{0, 0}; mi = '{0, 0};
    for (int c = 0; c < 400; c++) begin
      r8 = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      r6 = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      g8 = ($urandom_range(0, 3) != 0); g6 = ($urandom_range(0, 3) != 0);
      y8 = $urandom_range(0, 1);        y6 = $urandom_range(0, 1);
      drive8(r8, g8, y8);
      drive6(r6[5:0], g6, y6);
      @(negedge clk);

      model_eval(8, mp[0], ml[0], mi[0], r8, g8, y8, ev, es, ep, sk);
      m8 = sk ? 16'hFFFF : 16'h8FF8;
      checks++;
      if ((obs8() & m8) !== (exp8(ev, es, ep ? 8'(1 << es) : 8'h00, ep) & m8)) begin
        errors++; $display("FAIL random8 c=%0d: got %h expected %h", c, obs8() & m8, exp8(ev, es, ep ? 8'(1 << es) : 8'h00, ep) & m8);
      end
      if (ep) begin mp[0] = (es + 1) % 8; ml[0] = 1'b0; end
      else if (!ml[0] && ev) begin ml[0] = 1'b1; mi[0] = es; end

      model_eval(6, mp[1], ml[1], mi[1], {2'b00, r6[5:0]}, g6, y6, ev, es, ep, sk);
      m6 = sk ? 14'h3FFF : 14'h23F8;
      checks++;
      if ((obs6() & m6) !== (exp6(ev, es, ep ? 6'(1 << es) : 6'h00, ep) & m6)) begin
        errors++; $display("FAIL random6 c=%0d: got %h expected %h", c, obs6() & m6, exp6(ev, es, ep ? 6'(1 << es) : 6'h00, ep) & m6);
      end
      if (ep) begin mp[1] = (es + 1) % 6; ml[1] = 1'b0; end
      else if (!ml[1] && ev) begin ml[1] = 1'b1; mi[1] = es; end

      checks++;
      if (a8.wfifo_push_o !== |(a8.awready_o & a8.awvalid_i)) begin
        errors++; $display("FAIL random_push_inv c=%0d: got %b expected %b", c, a8.wfifo_push_o, |(a8.awready_o & a8.awvalid_i));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_all_ports();
    test_lock();
    test_fifo_stall();
    test_n6_wrap();
    test_reset_locked();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
